// File: rtl/terminal_vga_renderer.sv
// 80x30 character terminal rendered to 640x480@60 VGA through a fixed 3-cycle
// pixel pipeline: buffer read, external font ROM lookup, output registers.
module terminal_vga_renderer #(
  parameter int          COLUMNS    = 80,
  parameter int          ROWS       = 30,
  parameter logic [11:0] FOREGROUND = 12'hFFF,
  parameter logic [11:0] BACKGROUND = 12'h000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] terminalAddress,
  input  logic        shouldWriteTerminal,
  input  logic [7:0]  terminalWriteData,
  output logic [11:0] fontAddress,
  input  logic [7:0]  fontData,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue
);

  localparam int CELLS = COLUMNS * ROWS;

  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic [7:0]  buffer [CELLS];

  logic        visible_p0, hsync_p0, vsync_p0;
  logic [11:0] readAddress_p0;

  logic [7:0]  readData_p1;
  logic [3:0]  vLow_p1;
  logic [2:0]  hLow_p1;
  logic        visible_p1, hsync_p1, vsync_p1;

  logic        charZero_p2;
  logic [2:0]  hLow_p2;
  logic        visible_p2, hsync_p2, vsync_p2;

  logic        pixelOn;
  logic [11:0] colour;

  function automatic logic [11:0] pixelColour(input logic on, input logic visible);
    if (!visible)
      return 12'h000;
    return on ? FOREGROUND : BACKGROUND;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      hCount <= '0;
      vCount <= '0;
    end else if (hCount == 10'd799) begin
      hCount <= '0;
      vCount <= (vCount == 10'd524) ? 10'd0 : vCount + 10'd1;
    end else begin
      hCount <= hCount + 10'd1;
    end
  end

  // Buffer write port: never reset, out-of-range addresses dropped
  always_ff @(posedge clock) begin
    if (shouldWriteTerminal && (terminalAddress < 12'(CELLS)))
      buffer[terminalAddress] <= terminalWriteData;
  end

  // Stage 0: scan position to buffer address and raw sync levels
  always_comb begin
    visible_p0     = (hCount < 10'd640) && (vCount < 10'd480);
    hsync_p0       = !((hCount >= 10'd656) && (hCount <= 10'd751));
    vsync_p0       = !((vCount >= 10'd490) && (vCount <= 10'd491));
    readAddress_p0 = 12'd0;
    if (visible_p0)
      readAddress_p0 = 12'(vCount[9:4]) * 12'(COLUMNS) + 12'(hCount[9:3]);
  end

  // Stage 1: read-first buffer read; glyph row travels with the character
  always_ff @(posedge clock) begin
    if (reset) begin
      readData_p1 <= '0;
      vLow_p1     <= '0;
      hLow_p1     <= '0;
      visible_p1  <= 1'b0;
      hsync_p1    <= 1'b1;
      vsync_p1    <= 1'b1;
    end else begin
      readData_p1 <= buffer[readAddress_p0];
      vLow_p1     <= vCount[3:0];
      hLow_p1     <= hCount[2:0];
      visible_p1  <= visible_p0;
      hsync_p1    <= hsync_p0;
      vsync_p1    <= vsync_p0;
    end
  end

  assign fontAddress = {readData_p1, vLow_p1};

  // Stage 2: font ROM answers during this stage
  always_ff @(posedge clock) begin
    if (reset) begin
      charZero_p2 <= 1'b1;
      hLow_p2     <= '0;
      visible_p2  <= 1'b0;
      hsync_p2    <= 1'b1;
      vsync_p2    <= 1'b1;
    end else begin
      charZero_p2 <= (readData_p1 == 8'h00);
      hLow_p2     <= hLow_p1;
      visible_p2  <= visible_p1;
      hsync_p2    <= hsync_p1;
      vsync_p2    <= vsync_p1;
    end
  end

  // A NUL character is always blank whatever the ROM holds for it
  assign pixelOn = fontData[3'd7 - hLow_p2] && !charZero_p2;
  assign colour  = pixelColour(pixelOn, visible_p2);

  // Stage 3: output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      hsync <= hsync_p2;
      vsync <= vsync_p2;
      red   <= colour[11:8];
      green <= colour[7:4];
      blue  <= colour[3:0];
    end
  end

endmodule

// File: tb/tb_terminal_vga_renderer.sv
// Directed bench for terminal_vga_renderer with a behavioural 8x16 font ROM.
module tb_terminal_vga_renderer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] terminalAddress = '0;
  logic        shouldWriteTerminal = 1'b0;
  logic [7:0]  terminalWriteData = '0;
  logic [11:0] fontAddress;
  logic [7:0]  fontData = '0;
  logic        hsync, vsync;
  logic [3:0]  red, green, blue;

  int errors = 0;
  int checks = 0;
  logic [9:0] forceV;

  typedef struct {
    int          v;
    int          h;
    logic [11:0] rgb;
  } vec_t;

  vec_t vecs [16];

  terminal_vga_renderer dut (
    .clock(clock), .reset(reset),
    .terminalAddress(terminalAddress), .shouldWriteTerminal(shouldWriteTerminal),
    .terminalWriteData(terminalWriteData), .fontAddress(fontAddress),
    .fontData(fontData), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue)
  );

  always #20 clock = ~clock;

  // Font ROM model; NUL deliberately returns a solid row so blanking is observable
  function automatic logic [7:0] glyph(input logic [7:0] ch);
    case (ch)
      8'h00:   return 8'hFF;
      8'h41:   return 8'b1000_0001;
      8'h42:   return 8'hFF;
      8'h5A:   return 8'hF0;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clock) fontData <= glyph(fontAddress[11:4]);

  initial begin
    #20_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic advance(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  // Leaves the bench at a negedge with the scan at (hCount=0, vCount=v)
  task restartAt(input int v);
    forceV = 10'(v);
    reset = 1'b1;
    force dut.vCount = forceV;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    release dut.vCount;
  endtask

  task automatic writeByte(input logic [11:0] a, input logic [7:0] d);
    terminalAddress = a;
    terminalWriteData = d;
    shouldWriteTerminal = 1'b1;
    @(posedge clock);
    @(negedge clock);
    shouldWriteTerminal = 1'b0;
  endtask

  task automatic runTable(input string tag);
    for (int i = 0; i < 16; i++) begin
      restartAt(vecs[i].v);
      advance(vecs[i].h + 3);
      check($sformatf("%s v%0d h%0d", tag, vecs[i].v, vecs[i].h),
            32'({red, green, blue}), 32'(vecs[i].rgb));
    end
  endtask

  initial begin
    int firstFall, secondFall, lowCount;
    logic prev;

    vecs[0]  = '{0, 0, 12'hFFF};   vecs[1]  = '{0, 1, 12'h000};
    vecs[2]  = '{0, 6, 12'h000};   vecs[3]  = '{0, 7, 12'hFFF};
    vecs[4]  = '{0, 8, 12'h000};   vecs[5]  = '{0, 12, 12'h000};
    vecs[6]  = '{15, 0, 12'hFFF};  vecs[7]  = '{15, 7, 12'hFFF};
    vecs[8]  = '{16, 0, 12'h000};  vecs[9]  = '{479, 632, 12'hFFF};
    vecs[10] = '{479, 635, 12'hFFF}; vecs[11] = '{479, 636, 12'h000};
    vecs[12] = '{479, 639, 12'h000}; vecs[13] = '{470, 632, 12'hFFF};
    vecs[14] = '{480, 632, 12'h000}; vecs[15] = '{479, 624, 12'h000};

    // Fill the buffer while reset is held; writes must still land
    @(negedge clock);
    for (int a = 0; a < 2400; a++) writeByte(12'(a), 8'h00);
    writeByte(12'd0, 8'h41);
    writeByte(12'd2399, 8'h5A);

    check("reset hsync", 32'(hsync), 32'd1);
    check("reset vsync", 32'(vsync), 32'd1);
    check("reset rgb", 32'({red, green, blue}), 32'd0);
    check("reset fontAddress", 32'(fontAddress), 32'd0);

    // Horizontal sync timing from a fresh start
    restartAt(0);
    firstFall = -1; secondFall = -1; lowCount = 0; prev = hsync;
    for (int c = 0; c < 1600; c++) begin
      if (c < 800 && !hsync) lowCount++;
      if (prev && !hsync) begin
        if (firstFall < 0) firstFall = c;
        else if (secondFall < 0) secondFall = c;
      end
      prev = hsync;
      advance(1);
    end
    check("hsync first fall", 32'(firstFall), 32'd659);
    check("hsync low width", 32'(lowCount), 32'd96);
    check("hsync second fall", 32'(secondFall), 32'd1459);

    // Vertical sync: lines 490 and 491 only
    restartAt(488);
    advance(1602);
    check("vsync before pulse", 32'(vsync), 32'd1);
    advance(1);
    check("vsync pulse start", 32'(vsync), 32'd0);
    advance(1599);
    check("vsync pulse end", 32'(vsync), 32'd0);
    advance(1);
    check("vsync after pulse", 32'(vsync), 32'd1);

    runTable("pixel");

    restartAt(479);
    advance(633);
    check("fontAddress col79 line479", 32'(fontAddress), 32'({8'h5A, 4'hF}));

    // Out-of-range write must leave the screen unchanged
    writeByte(12'd2400, 8'hFF);
    writeByte(12'd4095, 8'hFF);
    runTable("after2400");

    // Same-cycle write and read of cell (row 0, column 5)
    restartAt(0);
    advance(40);
    terminalAddress = 12'd5;
    terminalWriteData = 8'h42;
    shouldWriteTerminal = 1'b1;
    @(posedge clock);
    @(negedge clock);
    shouldWriteTerminal = 1'b0;
    advance(2);
    check("readfirst old byte", 32'({red, green, blue}), 32'h000);
    advance(1);
    check("readfirst next read", 32'({red, green, blue}), 32'hFFF);
    advance(799);
    check("readfirst next row", 32'({red, green, blue}), 32'hFFF);

    // Mid-frame reset at (300, 200)
    restartAt(200);
    advance(300);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("midreset hsync", 32'(hsync), 32'd1);
    check("midreset vsync", 32'(vsync), 32'd1);
    check("midreset rgb", 32'({red, green, blue}), 32'd0);
    reset = 1'b0;
    advance(2);
    check("midreset pre-pixel", 32'({red, green, blue}), 32'h000);
    advance(1);
    check("midreset first pixel", 32'({red, green, blue}), 32'hFFF);
    firstFall = -1; prev = hsync;
    for (int c = 3; c < 800 && firstFall < 0; c++) begin
      if (prev && !hsync) firstFall = c;
      prev = hsync;
      if (firstFall < 0) advance(1);
    end
    check("midreset hsync fall", 32'(firstFall), 32'd659);
    check("midreset vsync idle", 32'(vsync), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
